fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor to the team's single-precision combinational multiplier. Widths are configurable, and the block adds:
- round-to-nearest-even
- special-value handling (zero, inf, NaN)
- underflow and invalid flags
- a valid/ready streaming handshake with full backpressure

It sits between operand-fetch and writeback in the FP datapath.

---
 rtl/fp_mul_pipe.sv | 152 +++++++++++++++
 tb/tb_fp_mul_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with round-to-nearest-even, special-value handling,
// overflow/underflow/invalid flags and a valid/ready handshake with full backpressure.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_ALL1 = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Returns {nan, inf, zero}; denormals count as zero.
  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2 -: EXP_W];
    f = x[MAN_W-1:0];
    classify = {(&e) && (|f), (&e) && !(|f), e == '0};
  endfunction

  function automatic logic [SW:0] round_rne(input logic [SW-1:0] sig, input logic guard,
                                            input logic sticky);
    round_rne = {1'b0, sig} + (SW+1)'(guard && (sticky || sig[0]));
  endfunction

  // Returns {overflow, underflow, invalid, result}.
  function automatic logic [W+2:0] pack_result(input logic sign, input logic nan,
                                               input logic inf, input logic zero,
                                               input logic signed [XW-1:0] exp,
                                               input logic [MAN_W-1:0] frac);
    if (nan || (inf && zero))
      pack_result = {3'b001, QNAN};
    else if (inf)
      pack_result = {3'b000, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero)
      pack_result = {3'b000, sign, {(W-1){1'b0}}};
    else if (exp >= EXP_ALL1)
      pack_result = {3'b100, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp <= EXP_ZERO)
      pack_result = {3'b010, sign, {(W-1){1'b0}}};
    else
      pack_result = {3'b000, sign, exp[EXP_W-1:0], frac};
  endfunction

  logic en;
  logic vld_p0, vld_p1, vld_p2, vld_p3;

  logic [W-1:0] a_p0, b_p0;

  logic                 sign_p1, nan_p1, inf_p1, zero_p1;
  logic [PW-1:0]        prod_p1;
  logic signed [XW-1:0] exp_p1;

  logic                 sign_p2, nan_p2, inf_p2, zero_p2;
  logic [MAN_W-1:0]     frac_p2;
  logic signed [XW-1:0] exp_p2;

  logic [W+2:0] pack_p3;

  assign en        = !vld_p3 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p3;
  assign {overflow, underflow, invalid, result} = pack_p3;

  // Stage 1: unpack, classify, multiply significands, sum exponents
  logic [2:0]           cls_a, cls_b;
  logic [SW-1:0]        sig_a, sig_b;
  logic signed [XW-1:0] ea_x, eb_x;

  assign cls_a = classify(a_p0);
  assign cls_b = classify(b_p0);
  assign sig_a = {1'b1, a_p0[MAN_W-1:0]};
  assign sig_b = {1'b1, b_p0[MAN_W-1:0]};
  assign ea_x  = {2'b00, a_p0[W-2 -: EXP_W]};
  assign eb_x  = {2'b00, b_p0[W-2 -: EXP_W]};

  // Stage 2: normalise, round to nearest even, renormalise on carry-out
  logic [PW-1:0]        norm;
  logic [SW-1:0]        sig_n;
  logic                 guard, sticky;
  logic [SW:0]          rounded;
  logic [MAN_W-1:0]     frac_n;
  logic signed [XW-1:0] exp_n;

  assign norm    = prod_p1[PW-1] ? prod_p1 : {prod_p1[PW-2:0], 1'b0};
  assign sig_n   = norm[PW-1 -: SW];
  assign guard   = norm[PW-1-SW];
  assign sticky  = |norm[PW-2-SW:0];
  assign rounded = round_rne(sig_n, guard, sticky);
  assign frac_n  = rounded[SW] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
  assign exp_n   = exp_p1 + $signed(XW'(prod_p1[PW-1])) + $signed(XW'(rounded[SW]));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a_p0    <= a;
      b_p0    <= b;
      sign_p1 <= a_p0[W-1] ^ b_p0[W-1];
      nan_p1  <= cls_a[2] | cls_b[2];
      inf_p1  <= cls_a[1] | cls_b[1];
      zero_p1 <= cls_a[0] | cls_b[0];
      prod_p1 <= sig_a * sig_b;
      exp_p1  <= ea_x + eb_x - BIAS;
      sign_p2 <= sign_p1;
      nan_p2  <= nan_p1;
      inf_p2  <= inf_p1;
      zero_p2 <= zero_p1;
      frac_p2 <= frac_n;
      exp_p2  <= exp_n;
    end
  end

  // Stage 3: special-value priority, exponent limits and pack
  always_ff @(posedge clk) begin
    if (rst)
      pack_p3 <= '0;
    else if (en)
      pack_p3 <= pack_result(sign_p2, nan_p2, inf_p2, zero_p2, exp_p2, frac_p2);
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: single-precision instance plus a half-width instance.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        overflow, underflow, invalid;
  logic [31:0] a, b, result;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic        h_overflow, h_underflow, h_invalid;
  logic [15:0] h_a, h_b, h_result;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one pair into an empty pipeline and reports result, flags and edges-to-valid.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        output logic [31:0] res, output logic [2:0] flg, output int lat);
    int w;
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    res = result;
    flg = {overflow, underflow, invalid};
    tick();
  endtask

  task automatic check_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] exp_res, input logic [2:0] exp_flg);
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    run_op(xa, xb, res, flg, lat);
    n_checks++;
    if ({res, flg} !== {exp_res, exp_flg}) begin
      n_fail++;
      $display("FAIL %s: got result=%h flags(ovf,unf,inv)=%b, expected result=%h flags=%b",
               name, res, flg, exp_res, exp_flg);
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges after accept, expected 3", name, lat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
    tick(); tick();
    n_checks++;
    if ({out_valid, result, overflow, underflow, invalid} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_state: got out_valid=%b result=%h flags=%b%b%b, expected all zero",
               out_valid, result, overflow, underflow, invalid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (h_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_half_out_valid: got %b expected 0", h_out_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    check_op("basic_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
  endtask

  task automatic test_rne;
    check_op("rne_tie_even", 32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000);
    check_op("rne_sticky_up", 32'h3F800801, 32'h3F800800, 32'h3F801002, 3'b000);
  endtask

  task automatic test_limits;
    check_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
    check_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    check_op("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    check_op("neg_overflow", 32'hFF000000, 32'h7F000000, 32'hFF800000, 3'b100);
  endtask

  task automatic test_specials;
    check_op("inf_times_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    check_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    check_op("nan_operand", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001);
    check_op("nan_times_zero", 32'h00000000, 32'hFFC00001, 32'h7FC00000, 3'b001);
    check_op("denorm_flush", 32'h00400000, 32'h40000000, 32'h00000000, 3'b000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] src [8];
    logic [31:0] exp_q [8];
    int got, first, last, stalls;
    src   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    exp_q = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    got = 0; first = -1; last = -1; stalls = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t < 8) begin
        a = src[t]; b = 32'h40000000; in_valid = 1'b1;
        if (!in_ready) stalls++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        if (got < 8) begin
          n_checks++;
          if (result !== exp_q[got]) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", got, result, exp_q[got]);
          end
        end
        got++;
        if (first < 0) first = t;
        last = t;
      end
    end
    n_checks++;
    if (got !== 8 || (last - first) !== 7 || stalls !== 0) begin
      n_fail++;
      $display("FAIL b2b_stream: got %0d results over %0d cycles with %0d input stalls, expected 8 over 8 with 0",
               got, last - first + 1, stalls);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] pe [4];
    logic [31:0] held;
    logic        acc;
    int sent, got, stall_cycles, bad_ready, unstable, extra;
    pa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    pb = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h40A00000};
    pe = '{32'h40400000, 32'h40C00000, 32'h41100000, 32'h41A00000};
    sent = 0; got = 0; stall_cycles = 0; bad_ready = 0; unstable = 0; extra = 0;
    held = '0;
    out_ready = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (sent < 4) begin
        in_valid = 1'b1; a = pa[sent]; b = pb[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (stall_cycles == 0) held = result;
        else if (result !== held) unstable++;
        if (in_ready) bad_ready++;
        stall_cycles++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent !== 4 || stall_cycles !== 5) begin
      n_fail++;
      $display("FAIL bp_accept: got %0d accepted with %0d stalled cycles, expected 4 and 5",
               sent, stall_cycles);
    end
    n_checks++;
    if (bad_ready !== 0 || unstable !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d cycles in_ready=1 and %0d result changes while stalled, expected 0 and 0",
               bad_ready, unstable);
    end
    n_checks++;
    if (held !== pe[0]) begin
      n_fail++;
      $display("FAIL bp_held_result: got %h expected %h", held, pe[0]);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (out_valid) begin
        if (got < 4) begin
          n_checks++;
          if (result !== pe[got]) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: got %h expected %h", got, result, pe[got]);
          end
        end else begin
          extra++;
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got !== 4 || extra !== 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, expected 4", got);
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, result, overflow, underflow, invalid} !== {2'b01, 35'h0}) begin
      n_fail++;
      $display("FAIL midflight_reset: got out_valid=%b in_ready=%b result=%h flags=%b%b%b, expected 0 1 00000000 000",
               out_valid, in_ready, result, overflow, underflow, invalid);
    end
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL midflight_stale: got %0d stale out_valid cycles, expected 0", stale);
    end
    check_op("after_reset_op", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
  endtask

  task automatic test_half;
    logic [15:0] ha [2];
    logic [15:0] hb [2];
    logic [15:0] he [2];
    logic [2:0]  hf [2];
    int lat, w;
    ha = '{16'h3E00, 16'h7800};
    hb = '{16'h4000, 16'h7800};
    he = '{16'h4200, 16'h7C00};
    hf = '{3'b000, 3'b100};
    h_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      h_a = ha[i]; h_b = hb[i]; h_in_valid = 1'b1;
      w = 0;
      while (!h_in_ready && w < 20) begin tick(); w++; end
      tick();
      h_in_valid = 1'b0;
      lat = 0;
      while (!h_out_valid && lat < 20) begin tick(); lat++; end
      n_checks++;
      if ({lat == 3, h_result, h_overflow, h_underflow, h_invalid} !== {1'b1, he[i], hf[i]}) begin
        n_fail++;
        $display("FAIL half[%0d]: got result=%h flags=%b%b%b latency=%0d, expected %h %b latency=3",
                 i, h_result, h_overflow, h_underflow, h_invalid, lat, he[i], hf[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rne();
    test_limits();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
